acc_chain_ctrl: RTL and testbench
=================================

Name: acc_chain_ctrl

Overview:
- Sequences the cascaded accumulator chain of one conv core for n×m kernels.
- Each step i (i>0) first absorbs its own multiplier "last" beat. On the following merge beat it muxes in accumulator i-1's last result.
- During the merge beat it freezes all multipliers and every accumulator except the merging one(s).
- Sits beside the stepped-delay datapath and drives the per-step mux selects and clock enables. It also detects loss of step synchronisation and reports it; in 1x1 mode it is transparent.

Parameters:
STEPS, 8, number of datapath steps (units) in the chain; ≥2.
TIMEOUT, 15, max beats a step may stay ARMED waiting for acc_last[i-1] before flagging sync error; ≥1.

Ports:
aclk  input  1  clock
aresetn  input  1  synchronous active-low reset
aclken  input  1  global clock enable; state only advances when high
is_1x1  input  1  config: 1 = 1x1 mode, chain merging disabled
mul_valid  input  STEPS  multiplier output valid per step (at mux input s1)
mul_last  input  STEPS  multiplier output last per step
acc_valid  input  STEPS  accumulator output valid per step
acc_last  input  STEPS  accumulator output last per step
mux_sel  output  STEPS  1 = accumulator i takes acc output of i-1; bit 0 always 0
mul_clken  output  1  enable for all multiplier pipelines
acc_clken  output  STEPS  per-step accumulator enable
chain_done  output  1  pulse: acc_valid&acc_last seen on step STEPS-1 while mul_clken high
sync_err  output  1  sticky: some step timed out in ARMED
err_step  output  clog2(STEPS)  index of first step that timed out

Behaviour:
- Reset (aresetn=0 at posedge): all step FSMs → IDLE; timeout counters 0; sync_err=0; err_step=0.
- Outputs after reset: mux_sel=0, mul_clken=aclken, acc_clken={STEPS{aclken}}, chain_done=0.
- Reset mid-merge aborts the merge; there is no partial-state retention.
- aclken=0: no register updates; mul_clken=0, acc_clken=0, chain_done=0.
- Per-step FSM, steps 1..STEPS-1 (step 0 has none):
  - IDLE → ARMED when mul_valid[i]&mul_last[i]&mul_clken&aclken&~is_1x1.
  - ARMED: merge[i] = acc_valid[i-1]&acc_last[i-1] (combinational, same cycle).
  - ARMED & merge[i] & aclken → IDLE; timeout counter cleared.
  - ARMED & ~merge[i] & aclken → counter+1. On reaching TIMEOUT: → IDLE, sync_err←1, and err_step←i only if sync_err was 0.
  - A new mul last in the same beat the step leaves ARMED re-arms it (ARMED→ARMED, counter 0).
- Combinational outputs (Mealy on registered state):
  - mux_sel[i] = (state[i]==ARMED); held until merge or timeout.
  - any_merge = OR of merge[i] over ARMED steps.
  - mul_clken = aclken & ~any_merge.
  - acc_clken[j] = aclken & (~any_merge | merge[j]).
  - Simultaneous merges on several steps: all merging accumulators are enabled; multipliers frozen one beat.
- chain_done = aclken & mul_clken & acc_valid[STEPS-1] & acc_last[STEPS-1]; single-cycle, combinational.
- is_1x1=1:
  - All FSMs are forced to IDLE next beat (counters cleared) and no arming occurs.
  - mux_sel=0, mul_clken=aclken, acc_clken=all aclken.
  - sync_err is unaffected (it stays sticky).
- Toggling is_1x1 mid-chain is illegal; the defined result is that armed steps drop to IDLE.
- sync_err clears only on reset.
- Latency:
  - IDLE→ARMED takes 1 cycle after the mul last beat.
  - The merge beat is the first cycle with acc_last[i-1] while ARMED; the freeze lasts exactly that beat.

Test Plan:
- Reset: aresetn=0 for 2 cycles with random inputs → mux_sel=0, sync_err=0, mul_clken=1, acc_clken=8'hFF (aclken=1).
- Nominal merge (STEPS=4): mul last on step 2 at t0; acc_last[1] at t0+1.
  - t0+1: mux_sel=4'b0100, mul_clken=0, acc_clken=4'b0100.
  - t0+2: mux_sel=0, all enables 1.
- Full stagger: steps 1..3 fed per the delay schedule → exactly three single-beat freezes, with chain_done pulsing once at step 3's final last.
- Timeout (TIMEOUT=3): arm step 1 and never send acc_last[0] → mux_sel[1]=1 for 3 beats, then sync_err=1, err_step=1, and mux_sel returns to 0.
- aclken stall: drop aclken for 5 cycles while step 2 is ARMED → state and counter frozen, all clkens 0; the merge completes on the first aclken=1 beat with acc_last[1].
- 1x1 mode: is_1x1=1 with mul_last on all steps → mux_sel stays 0, mul_clken=1, and no sync_err after 100 cycles.

Source files
------------

// File: rtl/acc_chain_ctrl.sv
// Sequencer for the cascaded accumulator chain of one conv core.
// Each step i>0 arms on its own multiplier "last" beat, then on the beat
// where accumulator i-1 presents its last result it muxes that result in.
// During that merge beat the multipliers and every non-merging accumulator
// are frozen. A step that waits too long for its upstream last raises a
// sticky sync error. In 1x1 mode the block is transparent.
module acc_chain_ctrl #(
  parameter int STEPS   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       aclken,
  input  logic                       is_1x1,
  input  logic [STEPS-1:0]           mul_valid,
  input  logic [STEPS-1:0]           mul_last,
  input  logic [STEPS-1:0]           acc_valid,
  input  logic [STEPS-1:0]           acc_last,
  output logic [STEPS-1:0]           mux_sel,
  output logic                       mul_clken,
  output logic [STEPS-1:0]           acc_clken,
  output logic                       chain_done,
  output logic                       sync_err,
  output logic [$clog2(STEPS)-1:0]   err_step
);

  localparam int IW = $clog2(STEPS);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;

  logic [0:0]     state [STEPS];
  logic [CW-1:0]  cnt   [STEPS];

  logic [STEPS-1:0] armed;
  logic [STEPS-1:0] merge;
  logic [STEPS-1:0] arm;
  logic [STEPS-1:0] tout;
  logic             any_merge;
  logic [IW-1:0]    first_tout;

  // Merge detection, freeze enables and per-step arm/timeout conditions
  always_comb begin
    armed      = '0;
    merge      = '0;
    tout       = '0;
    first_tout = '0;
    for (int i = 1; i < STEPS; i++) begin
      armed[i] = (state[i] == ARMED) & ~is_1x1;
      merge[i] = armed[i] & acc_valid[i-1] & acc_last[i-1];
    end
    any_merge  = |merge;
    mul_clken  = aclken & ~any_merge;
    acc_clken  = {STEPS{aclken}} & (~{STEPS{any_merge}} | merge);
    mux_sel    = armed;
    chain_done = mul_clken & acc_valid[STEPS-1] & acc_last[STEPS-1];
    // A last beat only counts when the multipliers actually advance
    arm        = mul_valid & mul_last & {STEPS{mul_clken & ~is_1x1}};
    arm[0]     = 1'b0;
    for (int i = 1; i < STEPS; i++) begin
      tout[i] = armed[i] & ~merge[i] & (cnt[i] == CW'(TIMEOUT - 1));
    end
    // Descending scan so the lowest timing-out step is reported
    for (int i = STEPS - 1; i >= 1; i--) begin
      if (tout[i]) first_tout = IW'(i);
    end
  end

  // Step FSMs, wait counters and the sticky error record
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < STEPS; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      sync_err <= 1'b0;
      err_step <= '0;
    end else if (aclken) begin
      for (int i = 1; i < STEPS; i++) begin
        if (is_1x1) begin
          state[i] <= IDLE;
          cnt[i]   <= '0;
        end else if (state[i] == IDLE) begin
          state[i] <= arm[i] ? ARMED : IDLE;
          cnt[i]   <= '0;
        end else if (merge[i] || tout[i]) begin
          // Leaving ARMED; a coincident last beat re-arms immediately
          state[i] <= arm[i] ? ARMED : IDLE;
          cnt[i]   <= '0;
        end else begin
          cnt[i]   <= cnt[i] + 1'b1;
        end
      end
      if ((|tout) && !sync_err) begin
        sync_err <= 1'b1;
        err_step <= first_tout;
      end
    end
  end

endmodule

// File: tb/tb_acc_chain_ctrl.sv
// Bench for acc_chain_ctrl: directed scenarios plus randomized traffic,
// all checked against a step-level behavioural model.
module tb_acc_chain_ctrl;

  localparam int S = 4;
  localparam int T = 3;

  logic         aclk = 1'b0;
  logic         aresetn, aclken, is_1x1;
  logic [S-1:0] mul_valid, mul_last, acc_valid, acc_last;
  logic [S-1:0] mux_sel, acc_clken;
  logic         mul_clken, chain_done, sync_err;
  logic [1:0]   err_step;

  int n_chk  = 0;
  int n_fail = 0;

  acc_chain_ctrl #(.STEPS(S), .TIMEOUT(T)) dut (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .is_1x1(is_1x1),
    .mul_valid(mul_valid), .mul_last(mul_last),
    .acc_valid(acc_valid), .acc_last(acc_last),
    .mux_sel(mux_sel), .mul_clken(mul_clken), .acc_clken(acc_clken),
    .chain_done(chain_done), .sync_err(sync_err), .err_step(err_step)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: per step, whether it waits for an upstream last and for how long
  bit m_waiting [S];
  int m_beats   [S];
  bit m_err;
  int m_err_step;

  function automatic void model_reset();
    for (int i = 0; i < S; i++) begin
      m_waiting[i] = 0;
      m_beats[i]   = 0;
    end
    m_err      = 0;
    m_err_step = 0;
  endfunction

  function automatic void model_outs(output logic [S-1:0] e_mux, output logic [S-1:0] e_acc,
                                     output logic [S-1:0] e_mrg, output logic e_mul,
                                     output logic e_done);
    bit any;
    e_mux = '0;
    e_mrg = '0;
    for (int i = 1; i < S; i++) begin
      if (m_waiting[i] && !is_1x1) begin
        e_mux[i] = 1'b1;
        if (acc_valid[i-1] && acc_last[i-1]) e_mrg[i] = 1'b1;
      end
    end
    any   = (e_mrg != 0);
    e_mul = aclken && !any;
    for (int j = 0; j < S; j++) e_acc[j] = aclken && (!any || e_mrg[j]);
    e_done = e_mul && acc_valid[S-1] && acc_last[S-1];
  endfunction

  function automatic void model_step();
    logic [S-1:0] e_mux, e_acc, e_mrg;
    logic         e_mul, e_done;
    int           first;
    bit           newl;
    if (!aresetn) begin
      model_reset();
      return;
    end
    if (!aclken) return;
    model_outs(e_mux, e_acc, e_mrg, e_mul, e_done);
    first = -1;
    for (int i = 1; i < S; i++) begin
      newl = mul_valid[i] && mul_last[i] && e_mul && !is_1x1;
      if (is_1x1) begin
        m_waiting[i] = 0;
        m_beats[i]   = 0;
      end else if (!m_waiting[i]) begin
        m_waiting[i] = newl;
        m_beats[i]   = 0;
      end else if (e_mrg[i]) begin
        m_waiting[i] = newl;
        m_beats[i]   = 0;
      end else begin
        m_beats[i]++;
        if (m_beats[i] == T) begin
          if (first < 0) first = i;
          m_waiting[i] = newl;
          m_beats[i]   = 0;
        end
      end
    end
    if (first >= 0 && !m_err) begin
      m_err      = 1;
      m_err_step = first;
    end
  endfunction

  task automatic apply(input logic rn, input logic en, input logic x1,
                       input logic [S-1:0] mv, input logic [S-1:0] ml,
                       input logic [S-1:0] av, input logic [S-1:0] al);
    aresetn   = rn;
    aclken    = en;
    is_1x1    = x1;
    mul_valid = mv;
    mul_last  = ml;
    acc_valid = av;
    acc_last  = al;
    #1;
  endtask

  task automatic check_model();
    logic [S-1:0] e_mux, e_acc, e_mrg;
    logic         e_mul, e_done;
    model_outs(e_mux, e_acc, e_mrg, e_mul, e_done);
    check("mux_sel",    mux_sel,    e_mux);
    check("mul_clken",  mul_clken,  e_mul);
    check("acc_clken",  acc_clken,  e_acc);
    check("chain_done", chain_done, e_done);
    check("sync_err",   sync_err,   m_err);
    check("err_step",   err_step,   m_err_step);
  endtask

  task automatic tick();
    @(posedge aclk);
    model_step();
    #1;
  endtask

  task automatic cycle(input logic rn, input logic en, input logic x1,
                       input logic [S-1:0] mv, input logic [S-1:0] ml,
                       input logic [S-1:0] av, input logic [S-1:0] al);
    apply(rn, en, x1, mv, ml, av, al);
    check_model();
    tick();
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++)
      cycle(1'b0, 1'b1, 1'b0, S'($urandom), S'($urandom), S'($urandom), S'($urandom));
  endtask

  int freezes, dones, sel_beats, bad;
  logic en_r, x1_r, rn_r;

  initial begin
    model_reset();
    apply(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
    @(posedge aclk);
    #1;

    // Reset with random inputs, then quiet-input values
    do_reset();
    apply(1'b1, 1'b1, 1'b0, '0, '0, '0, '0);
    check("rst_mux_sel",   mux_sel,   4'b0000);
    check("rst_sync_err",  sync_err,  1'b0);
    check("rst_err_step",  err_step,  2'd0);
    check("rst_mul_clken", mul_clken, 1'b1);
    check("rst_acc_clken", acc_clken, 4'b1111);
    check("rst_done",      chain_done, 1'b0);
    tick();

    // Nominal merge on step 2
    cycle(1'b1, 1'b1, 1'b0, 4'b0100, 4'b0100, '0, '0);
    apply(1'b1, 1'b1, 1'b0, '0, '0, 4'b0010, 4'b0010);
    check("nom_mux_sel",   mux_sel,   4'b0100);
    check("nom_mul_clken", mul_clken, 1'b0);
    check("nom_acc_clken", acc_clken, 4'b0100);
    check_model();
    tick();
    apply(1'b1, 1'b1, 1'b0, '0, '0, '0, '0);
    check("nom2_mux_sel",   mux_sel,   4'b0000);
    check("nom2_mul_clken", mul_clken, 1'b1);
    check("nom2_acc_clken", acc_clken, 4'b1111);
    check_model();
    tick();

    // Full stagger through steps 1..3
    freezes = 0;
    dones   = 0;
    for (int c = 0; c < 8; c++) begin
      logic [S-1:0] ml, al;
      ml = '0;
      al = '0;
      case (c)
        0: ml = 4'b0010;
        1: al = 4'b0001;
        2: ml = 4'b0100;
        3: al = 4'b0010;
        4: ml = 4'b1000;
        5: al = 4'b0100;
        6: al = 4'b1000;
        default: ;
      endcase
      apply(1'b1, 1'b1, 1'b0, ml, ml, al, al);
      check_model();
      if (!mul_clken) freezes++;
      if (chain_done) dones++;
      tick();
    end
    check("stagger_freezes", freezes, 3);
    check("stagger_dones",   dones,   1);

    // Timeout on step 1
    sel_beats = 0;
    cycle(1'b1, 1'b1, 1'b0, 4'b0010, 4'b0010, '0, '0);
    for (int c = 0; c < 5; c++) begin
      apply(1'b1, 1'b1, 1'b0, '0, '0, '0, '0);
      check_model();
      if (mux_sel[1]) sel_beats++;
      tick();
    end
    check("to_sel_beats", sel_beats, T);
    check("to_sync_err",  sync_err,  1'b1);
    check("to_err_step",  err_step,  2'd1);
    check("to_mux_sel",   mux_sel,   4'b0000);

    // aclken stall while step 2 waits
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 4'b0100, 4'b0100, '0, '0);
    for (int c = 0; c < 5; c++) begin
      apply(1'b1, 1'b0, 1'b0, '0, '0, 4'b0010, 4'b0010);
      check("stall_clkens", {mul_clken, acc_clken, chain_done}, 6'd0);
      check_model();
      tick();
    end
    apply(1'b1, 1'b1, 1'b0, '0, '0, 4'b0010, 4'b0010);
    check("stall_mux_sel",   mux_sel,   4'b0100);
    check("stall_mul_clken", mul_clken, 1'b0);
    check("stall_acc_clken", acc_clken, 4'b0100);
    check_model();
    tick();
    cycle(1'b1, 1'b1, 1'b0, '0, '0, '0, '0);
    check("stall_no_err", sync_err, 1'b0);

    // 1x1 mode
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      apply(1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, S'($urandom), S'($urandom));
      if (mux_sel != 0 || !mul_clken || acc_clken != 4'b1111) bad++;
      check_model();
      tick();
    end
    check("x1_bad_beats", bad, 0);
    check("x1_sync_err",  sync_err, 1'b0);

    // Randomized traffic
    do_reset();
    x1_r = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      logic [S-1:0] ml, al;
      rn_r = ($urandom_range(0, 199) != 0);
      en_r = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) x1_r = ~x1_r;
      ml = '0;
      al = '0;
      for (int b = 0; b < S; b++) begin
        ml[b] = ($urandom_range(0, 3) == 0);
        al[b] = ($urandom_range(0, 2) == 0);
      end
      cycle(rn_r, en_r, x1_r, S'($urandom) | ml, ml, S'($urandom) | al, al);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
